// File: rtl/oc_alu_pkg.sv
// oc_alu_pkg: shared op codes, FSM state type and ones'-complement helpers
// for the oc_seq_alu datapath.
package oc_alu_pkg;

  localparam logic [2:0] OP_AD   = 3'd0;
  localparam logic [2:0] OP_SU   = 3'd1;
  localparam logic [2:0] OP_MASK = 3'd2;
  localparam logic [2:0] OP_MP   = 3'd3;
  localparam logic [2:0] OP_DV   = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2
  } state_t;

  // Conditional ones'-complement negate. Passing a word's own sign as 'neg'
  // yields its magnitude; callers cast the result back to their width.
  function automatic logic [31:0] oc_cond_neg(input logic [31:0] x, input logic neg);
    return neg ? ~x : x;
  endfunction

endpackage

// File: rtl/oc_adder.sv
// oc_adder: DW-bit ones'-complement adder with end-around carry.
// A -0 (all ones) result is left as is; overflow flags a sign change when
// both inputs share a sign.
module oc_adder
  import oc_alu_pkg::*;
#(
  parameter int DW = 15
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  output logic [DW-1:0] sum,
  output logic          ovf
);

  logic [DW:0] raw;

  assign raw = {1'b0, x} + {1'b0, y};
  // Carry out of the top bit wraps back into bit 0; this never carries again.
  assign sum = raw[DW-1:0] + DW'(raw[DW]);
  assign ovf = (x[DW-1] == y[DW-1]) && (sum[DW-1] != x[DW-1]);

endmodule

// File: rtl/oc_seq_alu.sv
// oc_seq_alu: multi-cycle ones'-complement ALU with start/done handshake.
// AD/SU/MASK finish at the accept edge; MP (shift-add) and DV (restoring
// divide) iterate one magnitude bit per cycle and return hi/lo words.
// Optional: define OC_ALU_PARITY_CHECK_EN to check odd operand parity.
module oc_seq_alu
  import oc_alu_pkg::*;
#(
  parameter int DW = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW:0]   a,
  input  logic [DW:0]   b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] res_hi,
  output logic [DW-1:0] res_lo,
  output logic          overflow,
  output logic          div_zero,
  output logic          parity_err
);

  localparam int MW = DW - 1;          // magnitude width
  localparam int CW = $clog2(DW);

  logic [DW-1:0] a_dat, b_dat;
  logic [MW-1:0] mag_a, mag_b;
  logic [DW-1:0] add_x, add_y, add_sum;
  logic          add_ovf;
  logic          par_bad;

  assign a_dat = a[DW:1];
  assign b_dat = b[DW:1];
  assign mag_a = MW'(oc_cond_neg(32'(a_dat), a_dat[DW-1]));
  assign mag_b = MW'(oc_cond_neg(32'(b_dat), b_dat[DW-1]));

`ifdef OC_ALU_PARITY_CHECK_EN
  assign par_bad = ~(^a) | ~(^b);
`else
  logic unused_par;
  assign unused_par = a[0] ^ b[0];
  assign par_bad    = 1'b0;
`endif

  // SU computes B minus A as b + ~a on the same adder.
  assign add_x = (op == OP_SU) ? b_dat  : a_dat;
  assign add_y = (op == OP_SU) ? ~a_dat : b_dat;

  oc_adder #(.DW(DW)) u_adder (
    .x   (add_x),
    .y   (add_y),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] ma_q, ma_d;       // multiplicand / divisor magnitude
  logic [MW-1:0] wh_q, wh_d;       // MP high product / DV partial remainder
  logic [MW-1:0] wl_q, wl_d;       // MP low product / DV dividend->quotient
  logic          sgn_q, sgn_d;     // product / quotient sign
  logic          rsgn_q, rsgn_d;   // remainder sign
  logic          zero_q, zero_d;   // MP zero operand, DV zero divisor
  logic          par_q, par_d;
  logic [DW-1:0] bdat_q, bdat_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [DW-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic          ovf_q, ovf_d, dz_q, dz_d, perr_q, perr_d;

  logic [DW-1:0] mp_sum, dv_shift;
  logic          dv_ge;
  logic [MW-1:0] nxt_hi, nxt_lo;

  // One shift-add (MP) or restoring-divide (DV) step on the magnitude registers
  always_comb begin
    mp_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, ma_q} : '0);
    dv_shift = {wh_q, wl_q[MW-1]};
    dv_ge    = dv_shift >= {1'b0, ma_q};
    if (op_q == OP_MP) begin
      nxt_hi = mp_sum[DW-1:1];
      nxt_lo = {mp_sum[0], wl_q[MW-1:1]};
    end else begin
      // A restored value is below the divisor, so it fits in MW bits.
      nxt_hi = dv_ge ? MW'(dv_shift - {1'b0, ma_q}) : MW'(dv_shift);
      nxt_lo = {wl_q[MW-2:0], dv_ge};
    end
  end

  // FSM next state, operand capture and result/flag updates
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    ma_d     = ma_q;
    wh_d     = wh_q;
    wl_d     = wl_q;
    sgn_d    = sgn_q;
    rsgn_d   = rsgn_q;
    zero_d   = zero_q;
    par_d    = par_q;
    bdat_d   = bdat_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    ovf_d    = ovf_q;
    dz_d     = dz_q;
    perr_d   = perr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          par_d  = par_bad;
          ovf_d  = 1'b0;
          dz_d   = 1'b0;
          perr_d = 1'b0;
          case (op)
            OP_AD, OP_SU: begin
              res_hi_d = '0;
              res_lo_d = add_sum;
              ovf_d    = add_ovf;
              perr_d   = par_bad;
              done_d   = 1'b1;
            end
            OP_MASK: begin
              res_hi_d = '0;
              res_lo_d = a_dat & b_dat;
              perr_d   = par_bad;
              done_d   = 1'b1;
            end
            OP_MP, OP_DV: begin
              state_d = ITER;
              busy_d  = 1'b1;
              cnt_d   = CW'(DW - 1);
              ma_d    = mag_a;
              wh_d    = '0;
              wl_d    = mag_b;
              sgn_d   = a_dat[DW-1] ^ b_dat[DW-1];
              rsgn_d  = b_dat[DW-1];
              bdat_d  = b_dat;
              zero_d  = (op == OP_MP) ? ((mag_a == '0) || (mag_b == '0)) : (mag_a == '0);
            end
            default: begin
              res_hi_d = '0;
              res_lo_d = '0;
              done_d   = 1'b1;
            end
          endcase
        end
      end
      ITER: begin
        wh_d  = nxt_hi;
        wl_d  = nxt_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(2)) state_d = FINAL;
      end
      FINAL: begin
        // Last magnitude bit is folded in here, then signs are applied.
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        perr_d  = par_q;
        if (op_q == OP_MP) begin
          if (zero_q) begin
            res_hi_d = '0;
            res_lo_d = '0;
          end else begin
            res_hi_d = DW'(oc_cond_neg(32'({1'b0, nxt_hi}), sgn_q));
            res_lo_d = DW'(oc_cond_neg(32'({1'b0, nxt_lo}), sgn_q));
          end
        end else if (zero_q) begin
          dz_d     = 1'b1;
          res_lo_d = DW'(oc_cond_neg(32'({1'b0, {MW{1'b1}}}), sgn_q));
          res_hi_d = bdat_q;
        end else begin
          res_lo_d = DW'(oc_cond_neg(32'({1'b0, nxt_lo}), sgn_q));
          res_hi_d = DW'(oc_cond_neg(32'({1'b0, nxt_hi}), rsgn_q));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_AD;
      cnt_q    <= '0;
      ma_q     <= '0;
      wh_q     <= '0;
      wl_q     <= '0;
      sgn_q    <= 1'b0;
      rsgn_q   <= 1'b0;
      zero_q   <= 1'b0;
      par_q    <= 1'b0;
      bdat_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      ma_q     <= ma_d;
      wh_q     <= wh_d;
      wl_q     <= wl_d;
      sgn_q    <= sgn_d;
      rsgn_q   <= rsgn_d;
      zero_q   <= zero_d;
      par_q    <= par_d;
      bdat_q   <= bdat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      perr_q   <= perr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign res_hi     = res_hi_q;
  assign res_lo     = res_lo_q;
  assign overflow   = ovf_q;
  assign div_zero   = dz_q;
  assign parity_err = perr_q;

endmodule

// File: tb/tb_oc_seq_alu.sv
// tb_oc_seq_alu: directed + randomized checks of oc_seq_alu (DW=15) against
// an integer-arithmetic reference model.
module tb_oc_seq_alu;

  localparam int DW = 15;
`ifdef OC_ALU_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk, reset, start;
  logic [2:0]    op;
  logic [DW:0]   a, b;
  logic          busy, done, overflow, div_zero, parity_err;
  logic [DW-1:0] res_hi, res_lo;

  int checks   = 0;
  int failures = 0;

  oc_seq_alu #(.DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .res_hi     (res_hi),
    .res_lo     (res_lo),
    .overflow   (overflow),
    .div_zero   (div_zero),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [14:0] hi;
    logic [14:0] lo;
    logic        ovf;
    logic        dz;
  } res_t;

  // Reference: values as signed ones'-complement integers, plain arithmetic.
  function automatic res_t model(input int o, input int ad, input int bd);
    res_t r;
    int ma, mb, sa, sb, x, y, s, p, q, rm;
    r  = '0;
    sa = (ad >> 14) & 1;
    sb = (bd >> 14) & 1;
    ma = sa ? (ad ^ 'h7FFF) : ad;
    mb = sb ? (bd ^ 'h7FFF) : bd;
    case (o)
      0, 1: begin
        x = (o == 0) ? ad : bd;
        y = (o == 0) ? bd : (ad ^ 'h7FFF);
        s = x + y;
        if (s > 'h7FFF) s = s - 'h7FFF;   // arithmetic modulo 2^15-1
        r.lo  = 15'(s);
        r.ovf = ((x >> 14) == (y >> 14)) && ((s >> 14) != (x >> 14));
      end
      2: r.lo = 15'(ad & bd);
      3: begin
        if (ma != 0 && mb != 0) begin
          p    = ma * mb;
          r.hi = 15'(p / 16384);
          r.lo = 15'(p % 16384);
          if (sa != sb) begin
            r.hi = r.hi ^ 15'h7FFF;
            r.lo = r.lo ^ 15'h7FFF;
          end
        end
      end
      4: begin
        if (ma == 0) begin
          r.dz = 1'b1;
          r.lo = (sa != sb) ? 15'h4000 : 15'h3FFF;
          r.hi = 15'(bd);
        end else begin
          q    = mb / ma;
          rm   = mb % ma;
          r.lo = (sa != sb) ? 15'(q ^ 'h7FFF) : 15'(q);
          r.hi = (sb != 0) ? 15'(rm ^ 'h7FFF) : 15'(rm);
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for done (bounded), check timing and results.
  task automatic do_op(input logic [2:0] o, input logic [14:0] ad, input logic [14:0] bd,
                       input bit bad_a, input bit poke);
    res_t e;
    int   cyc, lat, extra;
    bit   multi;
    e     = model(int'(o), int'(ad), int'(bd));
    multi = (o == 3'd3) || (o == 3'd4);
    lat   = multi ? 15 : 1;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = {ad, (~^ad) ^ bad_a};
    b     = {bd, ~^bd};
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < 40) begin
      chk("busy_during", 32'(busy), 32'd1);
      if (poke && cyc == 5) begin
        start = 1'b1;
        op    = 3'd0;
        a     = {15'd7, 1'b0};
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    chk("latency",   32'(cyc),        32'(lat));
    chk("done",      32'(done),       32'd1);
    chk("busy_done", 32'(busy),       32'd0);
    chk("res_hi",    32'(res_hi),     32'(e.hi));
    chk("res_lo",    32'(res_lo),     32'(e.lo));
    chk("overflow",  32'(overflow),   32'(e.ovf));
    chk("div_zero",  32'(div_zero),   32'(e.dz));
    chk("parity",    32'(parity_err), 32'(PAR_EN & bad_a));
    @(posedge clk); #1;
    chk("done_pulse", 32'(done),   32'd0);
    chk("res_hold",   32'(res_lo), 32'(e.lo));
    if (poke) begin
      extra = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (done === 1'b1) extra++;
      end
      chk("no_second_done", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int dn;
    logic [14:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   32'(busy),       32'd0);
    chk("rst_done",   32'(done),       32'd0);
    chk("rst_hi",     32'(res_hi),     32'd0);
    chk("rst_lo",     32'(res_lo),     32'd0);
    chk("rst_ovf",    32'(overflow),   32'd0);
    chk("rst_dz",     32'(div_zero),   32'd0);
    chk("rst_perr",   32'(parity_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed steps
    do_op(3'd0, 15'd4, 15'd4, 0, 0);
    chk("ad_4_4", 32'(res_lo), 32'd8);
    do_op(3'd0, 15'd4, 15'h7FFB, 0, 0);
    chk("ad_neg0", 32'(res_lo), 32'h7FFF);
    do_op(3'd1, 15'd4, 15'd3, 0, 0);
    chk("su_m1", 32'(res_lo), 32'h7FFE);
    do_op(3'd1, 15'd4, 15'h7FFB, 0, 0);
    chk("su_m8", 32'(res_lo), 32'h7FF7);
    do_op(3'd0, 15'h3FFF, 15'd1, 0, 0);
    chk("ad_ovf", 32'(overflow), 32'd1);
    do_op(3'd2, 15'h5A3C, 15'h0FF0, 0, 0);
    do_op(3'd3, 15'd4, 15'd3, 0, 0);
    chk("mp_12", 32'(res_lo), 32'd12);
    do_op(3'd3, 15'h7FFB, 15'd3, 0, 0);
    chk("mp_neg_hi", 32'(res_hi), 32'h7FFF);
    chk("mp_neg_lo", 32'(res_lo), 32'h7FF3);
    do_op(3'd3, 15'd16383, 15'd16383, 0, 0);
    chk("mp_max_hi", 32'(res_hi), 32'd16382);
    chk("mp_max_lo", 32'(res_lo), 32'd1);
    do_op(3'd3, 15'h7FFF, 15'd9, 0, 0);
    chk("mp_negzero", 32'(res_lo), 32'd0);
    do_op(3'd4, 15'd2, 15'd10, 0, 0);
    chk("dv_q5", 32'(res_lo), 32'd5);
    do_op(3'd4, 15'h7FFD, 15'd11, 0, 0);
    chk("dv_qm5", 32'(res_lo), 32'h7FFA);
    chk("dv_r1",  32'(res_hi), 32'd1);
    do_op(3'd5, 15'd9, 15'd9, 0, 0);
    do_op(3'd3, 15'd100, 15'd200, 0, 1);
    do_op(3'd4, 15'd0, 15'd77, 0, 0);
    chk("dz_flag", 32'(div_zero), 32'd1);
    chk("dz_lo",   32'(res_lo),   32'h3FFF);

    // Reset in the middle of a divide: outputs clear at once, no done.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd4;
    a     = {15'd2, ~^15'd2};
    b     = {15'd11, ~^15'd11};
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy),     32'd0);
    chk("mid_rst_done", 32'(done),     32'd0);
    chk("mid_rst_lo",   32'(res_lo),   32'd0);
    chk("mid_rst_hi",   32'(res_hi),   32'd0);
    chk("mid_rst_dz",   32'(div_zero), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    chk("mid_rst_nodone", 32'(dn), 32'd0);
    do_op(3'd0, 15'd4, 15'd4, 0, 0);
    chk("after_rst_ad", 32'(res_lo), 32'd8);

    // Parity fault on A (a = 16'h0009)
    do_op(3'd0, 15'd4, 15'd4, 1, 0);
    do_op(3'd3, 15'd5, 15'd6, 1, 0);

    // Randomized operations
    repeat (40) begin
      ra = 15'($urandom);
      rb = 15'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 15'($urandom_range(0, 40));
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 0) ? 15'h0000 : 15'h7FFF;
      do_op(3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 7) == 0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
